// File: rtl/serial_byte_loader.sv
// Serial-to-parallel loader: assembles a WIDTH-bit word MSB-first, then drives
// data/store into a latch bank with setup, store-high and hold phases.
module serial_byte_loader #(
   parameter int WIDTH        = 8,
   parameter int STORE_CYCLES = 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     bit_in,
   input  logic                     bit_valid,
   input  logic                     abort,
   output logic                     ready,
   output logic [WIDTH-1:0]         data,
   output logic                     store,
   output logic [$clog2(WIDTH):0]   bit_count,
   output logic                     byte_done
);

   localparam int BW = $clog2(WIDTH) + 1;
   localparam int CW = (STORE_CYCLES > 1) ? $clog2(STORE_CYCLES) : 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STORE_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SHIFT = 3'd1,
      SETUP = 3'd2,
      STORE = 3'd3,
      HOLD  = 3'd4
   } state_t;

   state_t            state;
   logic [WIDTH-1:0]  sr;
   logic [CW-1:0]     store_cnt;

   // ready is a pure state decode: bits are only taken while assembling
   always_comb begin
      ready = 1'b0;
      case (state)
         IDLE, SHIFT: ready = 1'b1;
         default:     ready = 1'b0;
      endcase
   end

   // Main sequencer: shift-in, latch-safe write sequence, abort handling
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= IDLE;
         sr        <= {WIDTH{1'b0}};
         data      <= {WIDTH{1'b0}};
         store     <= 1'b0;
         store_cnt <= {CW{1'b0}};
         bit_count <= {BW{1'b0}};
         byte_done <= 1'b0;
      end else begin
         byte_done <= 1'b0;
         case (state)
            IDLE, SHIFT: begin
               if (abort) begin
                  state     <= IDLE;
                  bit_count <= {BW{1'b0}};
                  sr        <= {WIDTH{1'b0}};
               end else if (bit_valid) begin
                  sr <= {sr[WIDTH-2:0], bit_in};
                  if (bit_count == BIT_LAST) begin
                     // data only ever changes here, so it is stable for the whole write
                     data      <= {sr[WIDTH-2:0], bit_in};
                     bit_count <= {BW{1'b0}};
                     state     <= SETUP;
                  end else begin
                     bit_count <= bit_count + BW'(1);
                     state     <= SHIFT;
                  end
               end else begin
                  state <= state;
               end
            end
            SETUP: begin
               state     <= STORE;
               store     <= 1'b1;
               store_cnt <= {CW{1'b0}};
            end
            STORE: begin
               if (store_cnt == CNT_LAST) begin
                  state     <= HOLD;
                  store     <= 1'b0;
                  store_cnt <= {CW{1'b0}};
               end else begin
                  store_cnt <= store_cnt + CW'(1);
               end
            end
            HOLD: begin
               state     <= IDLE;
               byte_done <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               store     <= 1'b0;
               store_cnt <= {CW{1'b0}};
               bit_count <= {BW{1'b0}};
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_byte_loader.sv
// Directed bench for serial_byte_loader: stimulus pushes expected words, a
// monitor pops them on byte_done and checks data and a latch-bank model.
module tb_serial_byte_loader;

   localparam int WIDTH = 8;
   localparam int SC    = 2;

   logic       clk = 1'b0;
   logic       reset_n, bit_in, bit_valid, abort;
   logic       ready, store, byte_done;
   logic [7:0] data;
   logic [3:0] bit_count;
   logic [7:0] mem;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_word;
   int         store_len = 0;
   int         ready_low = 0;
   int         store_pulses = 0;
   int         pulses0;
   int         n;

   always #5 clk = ~clk;

   serial_byte_loader #(.WIDTH(WIDTH), .STORE_CYCLES(SC)) dut (
      .clk(clk), .reset_n(reset_n), .bit_in(bit_in), .bit_valid(bit_valid),
      .abort(abort), .ready(ready), .data(data), .store(store),
      .bit_count(bit_count), .byte_done(byte_done)
   );

   // byte_memory stand-in: transparent latch
   always_latch begin
      if (store) mem <= data;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: completed writes, store pulse width, ready-low window
   always @(posedge clk) begin
      #1;
      if (byte_done === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_byte_done", 32'd1, 32'd0);
         end else begin
            exp_word = exp_q.pop_front();
            check("data_word", {24'd0, data}, {24'd0, exp_word});
            check("mem_word", {24'd0, mem}, {24'd0, exp_word});
         end
      end
      if (store === 1'b1) store_len++;
      else if (store_len != 0) begin
         store_pulses++;
         if (reset_n) check("store_width", store_len, SC);
         store_len = 0;
      end
      if (ready === 1'b0) ready_low++;
      else if (ready_low != 0) begin
         if (reset_n) check("ready_low_width", ready_low, SC + 2);
         ready_low = 0;
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      bit_in    = b;
      bit_valid = 1'b1;
      @(negedge clk);
      bit_valid = 1'b0;
      bit_in    = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] w, input bit gaps, input bit expect_write);
      if (expect_write) exp_q.push_back(w);
      for (int i = 7; i >= 0; i--) begin
         send_bit(w[i]);
         check("bit_count", {28'd0, bit_count}, (8 - i) % 8);
         if (gaps && i > 0) begin
            for (int g = 0; g < 1 + ((7 - i) % 3); g++) begin
               step();
               check("bit_count_gap", {28'd0, bit_count}, 8 - i);
            end
         end
      end
   endtask

   task automatic wait_ready();
      int k = 0;
      while (ready !== 1'b1 && k < 20) begin
         step();
         k++;
      end
      check("ready_timeout", {31'd0, ready}, 32'd1);
   endtask

   initial begin
      reset_n = 1'b0; bit_valid = 1'b1; bit_in = 1'b1; abort = 1'b0;
      step(); step();
      check("rst_data", {24'd0, data}, 32'h00);
      check("rst_store", {31'd0, store}, 32'd0);
      check("rst_ready", {31'd0, ready}, 32'd1);
      check("rst_bit_count", {28'd0, bit_count}, 32'd0);
      check("rst_byte_done", {31'd0, byte_done}, 32'd0);
      bit_valid = 1'b0; bit_in = 1'b0; reset_n = 1'b1;
      step();

      // gapped word
      send_word(8'h3C, 1'b1, 1'b1);
      wait_ready();
      step();

      // back-to-back word with edge-by-edge timing
      send_word(8'hA5, 1'b0, 1'b1);
      check("e0_data", {24'd0, data}, 32'hA5);
      check("e0_ready", {31'd0, ready}, 32'd0);
      check("e0_store", {31'd0, store}, 32'd0);
      step();
      check("e1_store", {31'd0, store}, 32'd1);
      step();
      check("e2_store", {31'd0, store}, 32'd1);
      step();
      check("e3_store", {31'd0, store}, 32'd0);
      check("e3_ready", {31'd0, ready}, 32'd0);
      step();
      check("e4_byte_done", {31'd0, byte_done}, 32'd1);
      check("e4_ready", {31'd0, ready}, 32'd1);
      step();
      check("e5_byte_done", {31'd0, byte_done}, 32'd0);

      // partial word then abort
      pulses0 = store_pulses;
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      check("abort_pre_count", {28'd0, bit_count}, 32'd5);
      abort = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
      step();
      abort = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
      check("abort_count", {28'd0, bit_count}, 32'd0);
      check("abort_ready", {31'd0, ready}, 32'd1);
      check("abort_data", {24'd0, data}, 32'hA5);
      step(); step(); step();
      check("abort_no_store", store_pulses, pulses0);
      send_word(8'hFF, 1'b0, 1'b1);
      wait_ready();
      step();

      // abort and bit_valid held during the write sequence
      send_word(8'h5A, 1'b0, 1'b1);
      abort = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
      n = 0;
      while (ready !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      abort = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
      check("busy_steps", n, 4);
      check("busy_count", {28'd0, bit_count}, 32'd0);
      check("busy_data", {24'd0, data}, 32'h5A);
      step();
      send_word(8'hC3, 1'b0, 1'b1);
      wait_ready();
      step();

      // reset during the first STORE cycle
      send_word(8'h96, 1'b0, 1'b0);
      step();
      check("pre_rst_store", {31'd0, store}, 32'd1);
      reset_n = 1'b0;
      step();
      check("mid_rst_store", {31'd0, store}, 32'd0);
      check("mid_rst_data", {24'd0, data}, 32'h00);
      check("mid_rst_ready", {31'd0, ready}, 32'd1);
      check("mid_rst_count", {28'd0, bit_count}, 32'd0);
      reset_n = 1'b1;
      repeat (8) step();
      check("mid_rst_byte_done", {31'd0, byte_done}, 32'd0);

      check("queue_drained", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_byte_loader.md
# serial_byte_loader

Serial-to-parallel front end for the `byte_memory` latch bank. It accepts one bit per handshake and assembles a WIDTH-bit word MSB-first. It then drives `data` and a `store` pulse into `byte_memory` using a latch-safe sequence: data is set up before `store` rises, held while `store` is high, and held after `store` falls. Outputs connect directly to the `byte_memory` `data`/`store` inputs.

## Interface
- WIDTH, 8, word width; must be ≥ 2; matches the downstream memory width.
- STORE_CYCLES, 2, number of clock cycles `store` stays high; must be ≥ 1.

- clk  input  1  single system clock; all state updates on the rising edge.
- reset_n  input  1  reset, synchronous and active-low.
- bit_in  input  1  serial data bit.
- bit_valid  input  1  `bit_in` is valid this cycle.
- abort  input  1  discard the partially assembled word.
- ready  output  1  loader accepts bits; high only in IDLE and SHIFT.
- data  output  WIDTH  word presented to `byte_memory.data`.
- store  output  1  latch enable to `byte_memory.store`.
- bit_count  output  $clog2(WIDTH)+1  bits accepted into the current word.
- byte_done  output  1  one-cycle pulse marking a completed write.

## Operation
- The block has five states: IDLE, SHIFT, SETUP, STORE and HOLD. `ready` is a decode of the state.
- Accepting a bit:
  - A bit is accepted on an edge where `bit_valid && ready && !abort`.
  - On acceptance, the internal shift register updates as `{sr[WIDTH-2:0], bit_in}` and `bit_count` increments.
  - The first accepted bit moves IDLE to SHIFT.
- Completing a word:
  - The WIDTH-th accepted bit moves the block to SETUP.
  - On that same edge, the output register `data` loads the fully assembled word. Bit 0 of `data` is the last bit received.
  - On that same edge, `bit_count` clears to 0.
- Write sequence:
  - SETUP lasts 1 cycle with `store`=0. It then moves to STORE.
  - STORE lasts exactly STORE_CYCLES cycles with `store`=1, driven from a cycle counter. It then moves to HOLD.
  - HOLD lasts 1 cycle with `store`=0. It then moves to IDLE.
  - `byte_done` is registered and is high for the single cycle immediately after HOLD, which is the first IDLE cycle.
- `data` stability:
  - `data` changes only on the edge entering SETUP, or on reset.
  - `data` is stable throughout SETUP, STORE and HOLD.
  - Between words, `data` holds the last stored word.
- Abort:
  - `abort` in IDLE or SHIFT returns the block to IDLE, clears `bit_count` and clears the shift register.
  - Abort leaves `data` unchanged, and no `store` pulse is produced.
  - `abort` in SETUP, STORE or HOLD is ignored; the write always completes.
- Simultaneous `abort` and `bit_valid` while `ready` is high: abort wins and the bit is discarded.
- `bit_valid` while `ready` is low (SETUP, STORE, HOLD): the bit is ignored and not buffered.
- Reset values:
  - `data`=0, `store`=0, `bit_count`=0, `byte_done`=0.
  - State is IDLE, so `ready`=1.
  - The shift register and the STORE counter are 0.
- Reset during STORE: `store` drops on the reset edge. The contents of `byte_memory` are then undefined and are not checked.

## Timing
- Let E0 be the edge that accepts the WIDTH-th bit.
- E0: the block enters SETUP; `data` is valid and `ready`=0.
- E1: `store` rises.
- E1+STORE_CYCLES: `store` falls and the block enters HOLD.
- E2+STORE_CYCLES: the block enters IDLE with `ready`=1 and `byte_done`=1 for one cycle.
- `ready` is low for STORE_CYCLES+2 cycles, which is 4 cycles at the defaults.
- The earliest next bit is accepted on the edge after `ready` returns high.
- Back-to-back throughput is one word per WIDTH+STORE_CYCLES+2 cycles, which is 12 cycles at the defaults.
- All outputs are registered except `ready`, which is a state decode. There are no combinational paths from inputs to outputs.

## Test plan
- Hold `reset_n`=0 for 2 cycles with `bit_valid`=1 and `bit_in`=1 → `data`=0x00, `store`=0, `ready`=1, `bit_count`=0, `byte_done`=0.
- Send bits 1,0,1,0,0,1,0,1 back-to-back → after E0, `data`=0xA5; `store` is high for exactly 2 cycles starting at E1; `byte_done` pulses once at E4; the attached `byte_memory` reads 0xA5.
- Send 0x3C with 1–3 idle cycles between bits → `bit_count` holds steady during the gaps; `data`=0x3C, one `store` pulse, memory reads 0x3C.
- After a stored 0xA5, send 5 bits then `abort` → `bit_count`=0 and `data` stays 0xA5 with no `store` pulse; then send 0xFF → memory reads 0xFF.
- Hold `bit_valid`=1 and `abort`=1 through SETUP, STORE and HOLD → the write completes unchanged, the bits are ignored, `ready` is low for 4 cycles, and the next word starts at `bit_count`=0.
- Assert `reset_n`=0 during the first STORE cycle → on the next edge `store`=0, `data`=0x00, the block is in IDLE with `ready`=1, and `byte_done` never pulses.
